// File: rtl/risc_pkg.sv
// Shared definitions for the decode stage: opcode map, ALU function codes,
// branch codes, control-word layout and the load-use hazard test.
package risc_pkg;

    localparam int OP_W = 7;
    localparam int FS_W = 4;
    localparam int BS_W = 2;
    localparam int RA_W = 5;

    localparam logic [OP_W-1:0] OP_MOVA = 7'h00;
    localparam logic [OP_W-1:0] OP_ADD  = 7'h02;
    localparam logic [OP_W-1:0] OP_SUB  = 7'h05;
    localparam logic [OP_W-1:0] OP_AND  = 7'h08;
    localparam logic [OP_W-1:0] OP_OR   = 7'h09;
    localparam logic [OP_W-1:0] OP_LD   = 7'h10;
    localparam logic [OP_W-1:0] OP_ST   = 7'h20;
    localparam logic [OP_W-1:0] OP_ADI  = 7'h42;
    localparam logic [OP_W-1:0] OP_BZ   = 7'h60;
    localparam logic [OP_W-1:0] OP_BNZ  = 7'h61;
    localparam logic [OP_W-1:0] OP_JMP  = 7'h70;

    localparam logic [FS_W-1:0] FS_MOVA = 4'h0;
    localparam logic [FS_W-1:0] FS_ADD  = 4'h2;
    localparam logic [FS_W-1:0] FS_SUB  = 4'h5;
    localparam logic [FS_W-1:0] FS_AND  = 4'h8;
    localparam logic [FS_W-1:0] FS_OR   = 4'h9;

    localparam logic [BS_W-1:0] BS_NONE = 2'b00;
    localparam logic [BS_W-1:0] BS_BZ   = 2'b01;
    localparam logic [BS_W-1:0] BS_BNZ  = 2'b10;
    localparam logic [BS_W-1:0] BS_JMP  = 2'b11;

    typedef struct packed {
        logic            cs;
        logic            mb;
        logic            rw;
        logic            md;
        logic            mw;
        logic [FS_W-1:0] fs;
        logic [BS_W-1:0] bs;
        logic            illegal;
    } ctrl_t;

    localparam ctrl_t CTRL_NOP = '0;

    typedef enum logic {
        ST_RUN    = 1'b0,
        ST_BUBBLE = 1'b1
    } ilk_state_t;

    // R0 is hardwired, so a load targeting it can never feed a consumer.
    function automatic logic loadUseHazard(
        input logic [RA_W-1:0] daHeld,
        input logic [RA_W-1:0] aaIn,
        input logic [RA_W-1:0] baIn,
        input logic            mbIn
    );
        return (daHeld != '0) && ((aaIn == daHeld) || ((baIn == daHeld) && !mbIn));
    endfunction

endpackage

// File: rtl/ctrl_decoder.sv
// Combinational opcode-to-control-word table; unknown opcodes yield a NOP
// control word with illegal set.
module ctrl_decoder
    import risc_pkg::*;
(
    input  logic [6:0] opcode,
    output logic       cs,
    output logic       mb,
    output logic       rw,
    output logic       md,
    output logic       mw,
    output logic [3:0] fs,
    output logic [1:0] bs,
    output logic       illegal
);

    ctrl_t c;

    always_comb begin
        c = CTRL_NOP;
        case (opcode)
            OP_MOVA: begin c.rw = 1'b1; c.fs = FS_MOVA; end
            OP_ADD:  begin c.rw = 1'b1; c.fs = FS_ADD;  end
            OP_SUB:  begin c.rw = 1'b1; c.fs = FS_SUB;  end
            OP_AND:  begin c.rw = 1'b1; c.fs = FS_AND;  end
            OP_OR:   begin c.rw = 1'b1; c.fs = FS_OR;   end
            OP_ADI:  begin c.cs = 1'b1; c.mb = 1'b1; c.rw = 1'b1; c.fs = FS_ADD; end
            OP_LD:   begin c.rw = 1'b1; c.md = 1'b1; c.fs = FS_MOVA; end
            OP_ST:   begin c.mw = 1'b1; c.fs = FS_MOVA; end
            // Conditional branches carry a signed offset in IM; JMP takes its target from A.
            OP_BZ:   begin c.cs = 1'b1; c.bs = BS_BZ;  c.fs = FS_MOVA; end
            OP_BNZ:  begin c.cs = 1'b1; c.bs = BS_BNZ; c.fs = FS_MOVA; end
            OP_JMP:  begin c.bs = BS_JMP; c.fs = FS_MOVA; end
            default: c.illegal = 1'b1;
        endcase
    end

    assign cs      = c.cs;
    assign mb      = c.mb;
    assign rw      = c.rw;
    assign md      = c.md;
    assign mw      = c.mw;
    assign fs      = c.fs;
    assign bs      = c.bs;
    assign illegal = c.illegal;

endmodule

// File: rtl/instr_decode_stage.sv
// Decode pipeline register with valid/ready handshake, flush and a one-bubble
// load-use interlock; 1-cycle latency, full throughput, outputs hold under backpressure.
module instr_decode_stage
    import risc_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int RADDR_W = 5,
    parameter int IMM_W   = 15
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [DATA_W-1:0]  instr,
    input  logic [DATA_W-1:0]  pc,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [DATA_W-1:0]  pc_q,
    output logic [RADDR_W-1:0] da,
    output logic [RADDR_W-1:0] aa,
    output logic [RADDR_W-1:0] ba,
    output logic [IMM_W-1:0]   im,
    output logic               cs,
    output logic               mb,
    output logic               rw,
    output logic               md,
    output logic               mw,
    output logic [3:0]         fs,
    output logic [1:0]         bs,
    output logic               illegal
);

    logic [OP_W-1:0]    opIn;
    logic [RADDR_W-1:0] daIn;
    logic [RADDR_W-1:0] aaIn;
    logic [RADDR_W-1:0] baIn;
    logic [IMM_W-1:0]   imIn;

    assign opIn = instr[DATA_W-1 -: OP_W];
    assign daIn = instr[DATA_W-OP_W-1 -: RADDR_W];
    assign aaIn = instr[DATA_W-OP_W-RADDR_W-1 -: RADDR_W];
    // BA deliberately overlaps the top of IM.
    assign baIn = instr[IMM_W-1 -: RADDR_W];
    assign imIn = instr[IMM_W-1:0];

    ctrl_t decCtrl;

    ctrl_decoder uDecoder (
        .opcode  (opIn),
        .cs      (decCtrl.cs),
        .mb      (decCtrl.mb),
        .rw      (decCtrl.rw),
        .md      (decCtrl.md),
        .mw      (decCtrl.mw),
        .fs      (decCtrl.fs),
        .bs      (decCtrl.bs),
        .illegal (decCtrl.illegal)
    );

    ilk_state_t         state;
    logic               validQ;
    logic [DATA_W-1:0]  pcQ;
    logic [RADDR_W-1:0] daQ;
    logic [RADDR_W-1:0] aaQ;
    logic [RADDR_W-1:0] baQ;
    logic [IMM_W-1:0]   imQ;
    ctrl_t              ctrlQ;

    logic leaving;
    logic canAdvance;
    logic loadHeld;
    logic stall;
    logic accept;

    assign leaving    = validQ & out_ready;
    assign canAdvance = ~validQ | out_ready;
    assign loadHeld   = validQ & ctrlQ.md & ctrlQ.rw;

    // Stall only when the load is actually departing; otherwise backpressure already blocks intake.
    assign stall = (state == ST_RUN) & in_valid & loadHeld & leaving
                 & loadUseHazard(daQ, aaIn, baIn, decCtrl.mb);

    // Flush keeps the port open so fetch can drain the wrong path; its instruction is dropped.
    assign in_ready = ~rst & (flush | (canAdvance & ~stall));
    assign accept   = in_valid & in_ready & ~flush;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= ST_RUN;
            validQ <= 1'b0;
            pcQ    <= '0;
            daQ    <= '0;
            aaQ    <= '0;
            baQ    <= '0;
            imQ    <= '0;
            ctrlQ  <= CTRL_NOP;
        end else if (flush) begin
            state  <= ST_RUN;
            validQ <= 1'b0;
        end else begin
            case (state)
                ST_RUN:    if (stall) state <= ST_BUBBLE;
                ST_BUBBLE: state <= ST_RUN;
                default:   state <= ST_RUN;
            endcase

            if (accept) begin
                validQ <= 1'b1;
                pcQ    <= pc;
                daQ    <= daIn;
                aaQ    <= aaIn;
                baQ    <= baIn;
                imQ    <= imIn;
                ctrlQ  <= decCtrl;
            end else if (leaving) begin
                validQ <= 1'b0;
            end
        end
    end

    assign out_valid = validQ;
    assign pc_q      = pcQ;
    assign da        = daQ;
    assign aa        = aaQ;
    assign ba        = baQ;
    assign im        = imQ;
    assign cs        = ctrlQ.cs;
    assign mb        = ctrlQ.mb;
    assign rw        = ctrlQ.rw;
    assign md        = ctrlQ.md;
    assign mw        = ctrlQ.mw;
    assign fs        = ctrlQ.fs;
    assign bs        = ctrlQ.bs;
    assign illegal   = ctrlQ.illegal;

endmodule

// File: tb/tb_instr_decode_stage.sv
// Scoreboard bench for instr_decode_stage: directed vectors push expected bundles,
// a negedge monitor pops and compares every bundle that transfers out.
module tb_instr_decode_stage;

    localparam logic [6:0] MOVA = 7'h00, ADD = 7'h02, SUB = 7'h05, ANDI = 7'h08, ORI = 7'h09;
    localparam logic [6:0] LD = 7'h10, ST = 7'h20, ADI = 7'h42, BZ = 7'h60, BNZ = 7'h61, JMP = 7'h70;

    typedef struct packed {
        logic [31:0] pc;
        logic [4:0]  da;
        logic [4:0]  aa;
        logic [4:0]  ba;
        logic [14:0] im;
        logic        cs;
        logic        mb;
        logic        rw;
        logic        md;
        logic        mw;
        logic [3:0]  fs;
        logic [1:0]  bs;
        logic        ill;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst, flush, in_valid, in_ready, out_valid, out_ready;
    logic [31:0] instr, pc, pc_q;
    logic [4:0]  da, aa, ba;
    logic [14:0] im;
    logic        cs, mb, rw, md, mw, illegal;
    logic [3:0]  fs;
    logic [1:0]  bs;

    int   nChecks = 0;
    int   nErrors = 0;
    exp_t expQ[$];
    exp_t got, want;

    instr_decode_stage dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .instr(instr), .pc(pc),
        .out_valid(out_valid), .out_ready(out_ready), .pc_q(pc_q),
        .da(da), .aa(aa), .ba(ba), .im(im), .cs(cs), .mb(mb),
        .rw(rw), .md(md), .mw(mw), .fs(fs), .bs(bs), .illegal(illegal)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act !== exp) begin
            nErrors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] mkI(input logic [6:0] op, input logic [4:0] d,
                                        input logic [4:0] a, input logic [14:0] lo);
        return {op, d, a, lo};
    endfunction

    // Expected bundle with fields written out by hand.
    function automatic exp_t mkE(input logic [31:0] p, input logic [4:0] d, input logic [4:0] a,
                                 input logic [4:0] b, input logic [14:0] i,
                                 input logic c, input logic m, input logic r, input logic mdv,
                                 input logic mwv, input logic [3:0] f, input logic [1:0] bsv,
                                 input logic il);
        exp_t e;
        e = '{pc: p, da: d, aa: a, ba: b, im: i, cs: c, mb: m, rw: r, md: mdv, mw: mwv,
              fs: f, bs: bsv, ill: il};
        return e;
    endfunction

    // Presents one instruction until accepted; waited counts cycles spent with in_ready low.
    task automatic issue(input logic [31:0] ins, input logic [31:0] p, input exp_t e,
                         output int waited);
        bit done;
        instr    = ins;
        pc       = p;
        in_valid = 1'b1;
        waited   = 0;
        done     = 0;
        for (int k = 0; k < 20 && !done; k++) begin
            @(negedge clk);
            if (in_ready) begin
                expQ.push_back(e);
                @(posedge clk);
                #1;
                done = 1;
            end else begin
                waited++;
            end
        end
        if (!done) begin
            nChecks++;
            nErrors++;
            $display("FAIL issue_timeout: in_ready stayed 0 for pc %0h, expected acceptance", p);
        end
        in_valid = 1'b0;
    endtask

    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            got = {pc_q, da, aa, ba, im, cs, mb, rw, md, mw, fs, bs, illegal};
            nChecks++;
            if (expQ.size() == 0) begin
                nErrors++;
                $display("FAIL unexpected_bundle: got %h, expected no bundle", got);
            end else begin
                want = expQ.pop_front();
                if (got !== want) begin
                    nErrors++;
                    $display("FAIL bundle pc=%0h: got %h, expected %h", want.pc, got, want);
                end
            end
        end
    end

    initial begin
        int w;
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        instr = '0; pc = '0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_in_ready", {31'd0, in_ready}, 32'd0);
        check("rst_ctrl", {20'd0, cs, mb, rw, md, mw, fs, bs, illegal}, 32'd0);
        @(negedge clk) rst = 1'b0;
        @(posedge clk) #1;
        check("rel_in_ready", {31'd0, in_ready}, 32'd1);

        // ADI R3 <- R1 + se(0x4000); BA overlaps IM so ba = 16
        issue(mkI(ADI, 5'd3, 5'd1, 15'h4000), 32'h100,
              mkE(32'h100, 5'd3, 5'd1, 5'd16, 15'h4000, 1, 1, 1, 0, 0, 4'h2, 2'b00, 0), w);
        check("adi_valid", {31'd0, out_valid}, 32'd1);
        check("adi_da", {27'd0, da}, 32'd3);
        check("adi_im", {17'd0, im}, 32'h4000);
        check("adi_cs_mb_rw", {29'd0, cs, mb, rw}, 32'd7);
        @(posedge clk) #1;

        // Backpressure: SUB held for 3 cycles while AND waits
        out_ready = 1'b0;
        issue(mkI(SUB, 5'd7, 5'd2, 15'h1003), 32'h104,
              mkE(32'h104, 5'd7, 5'd2, 5'd4, 15'h1003, 0, 0, 1, 0, 0, 4'h5, 2'b00, 0), w);
        instr = mkI(ANDI, 5'd8, 5'd6, 15'h0C00); pc = 32'h108; in_valid = 1'b1;
        repeat (3) begin
            @(posedge clk) #2;
            check("bp_in_ready", {31'd0, in_ready}, 32'd0);
            check("bp_hold", {out_valid, 26'd0, da}, {1'b1, 26'd0, 5'd7});
        end
        out_ready = 1'b1;
        issue(mkI(ANDI, 5'd8, 5'd6, 15'h0C00), 32'h108,
              mkE(32'h108, 5'd8, 5'd6, 5'd3, 15'h0C00, 0, 0, 1, 0, 0, 4'h8, 2'b00, 0), w);
        check("bp_release_wait", w, 32'd0);
        check("bp_second", {out_valid, 26'd0, da}, {1'b1, 26'd0, 5'd8});

        // Load-use via AA: one bubble, ADD not lost
        issue(mkI(LD, 5'd5, 5'd1, 15'h0000), 32'h10C,
              mkE(32'h10C, 5'd5, 5'd1, 5'd0, 15'h0000, 0, 0, 1, 1, 0, 4'h0, 2'b00, 0), w);
        instr = mkI(ADD, 5'd6, 5'd5, 15'h0800); pc = 32'h110; in_valid = 1'b1;
        #3;
        check("lu_stall", {31'd0, in_ready}, 32'd0);
        @(posedge clk) #1;
        check("lu_bubble", {31'd0, out_valid}, 32'd0);
        issue(mkI(ADD, 5'd6, 5'd5, 15'h0800), 32'h110,
              mkE(32'h110, 5'd6, 5'd5, 5'd2, 15'h0800, 0, 0, 1, 0, 0, 4'h2, 2'b00, 0), w);
        check("lu_after_wait", w, 32'd0);

        // Load to R0: no interlock
        issue(mkI(LD, 5'd0, 5'd2, 15'h0000), 32'h114,
              mkE(32'h114, 5'd0, 5'd2, 5'd0, 15'h0000, 0, 0, 1, 1, 0, 4'h0, 2'b00, 0), w);
        issue(mkI(ADD, 5'd9, 5'd0, 15'h0000), 32'h118,
              mkE(32'h118, 5'd9, 5'd0, 5'd0, 15'h0000, 0, 0, 1, 0, 0, 4'h2, 2'b00, 0), w);
        check("lu_r0_wait", w, 32'd0);

        // BA match with constant B operand: no interlock
        issue(mkI(LD, 5'd4, 5'd1, 15'h0000), 32'h11C,
              mkE(32'h11C, 5'd4, 5'd1, 5'd0, 15'h0000, 0, 0, 1, 1, 0, 4'h0, 2'b00, 0), w);
        issue(mkI(ADI, 5'd2, 5'd1, 15'h1000), 32'h120,
              mkE(32'h120, 5'd2, 5'd1, 5'd4, 15'h1000, 1, 1, 1, 0, 0, 4'h2, 2'b00, 0), w);
        check("lu_mb_wait", w, 32'd0);

        // BA match with register B operand: one bubble
        issue(mkI(LD, 5'd4, 5'd1, 15'h0000), 32'h124,
              mkE(32'h124, 5'd4, 5'd1, 5'd0, 15'h0000, 0, 0, 1, 1, 0, 4'h0, 2'b00, 0), w);
        issue(mkI(SUB, 5'd2, 5'd1, 15'h1000), 32'h128,
              mkE(32'h128, 5'd2, 5'd1, 5'd4, 15'h1000, 0, 0, 1, 0, 0, 4'h5, 2'b00, 0), w);
        check("lu_ba_wait", w, 32'd1);

        // Branch / store table through the scoreboard
        issue(mkI(ST, 5'd0, 5'd3, 15'h1400), 32'h12C,
              mkE(32'h12C, 5'd0, 5'd3, 5'd5, 15'h1400, 0, 0, 0, 0, 1, 4'h0, 2'b00, 0), w);
        issue(mkI(BZ, 5'd0, 5'd1, 15'h7FFC), 32'h130,
              mkE(32'h130, 5'd0, 5'd1, 5'd31, 15'h7FFC, 1, 0, 0, 0, 0, 4'h0, 2'b01, 0), w);
        issue(mkI(BNZ, 5'd0, 5'd2, 15'h0010), 32'h134,
              mkE(32'h134, 5'd0, 5'd2, 5'd0, 15'h0010, 1, 0, 0, 0, 0, 4'h0, 2'b10, 0), w);
        issue(mkI(JMP, 5'd0, 5'd7, 15'h0000), 32'h138,
              mkE(32'h138, 5'd0, 5'd7, 5'd0, 15'h0000, 0, 0, 0, 0, 0, 4'h0, 2'b11, 0), w);
        @(posedge clk) #1;

        // Flush with a held bundle and an incoming instruction
        out_ready = 1'b0;
        issue(mkI(ORI, 5'd9, 5'd1, 15'h0400), 32'h13C,
              mkE(32'h13C, 5'd9, 5'd1, 5'd1, 15'h0400, 0, 0, 1, 0, 0, 4'h9, 2'b00, 0), w);
        instr = mkI(MOVA, 5'd10, 5'd2, 15'h0000); pc = 32'h140; in_valid = 1'b1; flush = 1'b1;
        #3;
        check("flush_in_ready", {31'd0, in_ready}, 32'd1);
        @(posedge clk) #1;
        flush = 1'b0; in_valid = 1'b0;
        expQ.delete(expQ.size() - 1);
        check("flush_valid", {31'd0, out_valid}, 32'd0);
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("flush_no_reappear", {31'd0, out_valid}, 32'd0);

        // Illegal opcode, then a legal one
        issue(mkI(7'h7F, 5'd11, 5'd12, 15'h3400), 32'h144,
              mkE(32'h144, 5'd11, 5'd12, 5'd13, 15'h3400, 0, 0, 0, 0, 0, 4'h0, 2'b00, 1), w);
        check("ill_flag", {out_valid, 30'd0, illegal}, {1'b1, 30'd0, 1'b1});
        issue(mkI(MOVA, 5'd14, 5'd3, 15'h0000), 32'h148,
              mkE(32'h148, 5'd14, 5'd3, 5'd0, 15'h0000, 0, 0, 1, 0, 0, 4'h0, 2'b00, 0), w);
        check("ill_cleared", {31'd0, illegal}, 32'd0);
        @(posedge clk) #1;

        // Asynchronous reset mid-cycle while a load is held
        out_ready = 1'b0;
        issue(mkI(LD, 5'd9, 5'd1, 15'h0000), 32'h14C,
              mkE(32'h14C, 5'd9, 5'd1, 5'd0, 15'h0000, 0, 0, 1, 1, 0, 4'h0, 2'b00, 0), w);
        #3 rst = 1'b1;
        #1;
        check("arst_valid_ready", {30'd0, out_valid, in_ready}, 32'd0);
        check("arst_fields", {da, rw, md, 21'd0}, 32'd0);
        check("arst_pc", pc_q, 32'd0);
        expQ.delete();
        @(negedge clk) rst = 1'b0;
        out_ready = 1'b1;
        @(posedge clk) #1;
        check("arst_release_ready", {31'd0, in_ready}, 32'd1);
        issue(mkI(ADD, 5'd1, 5'd9, 15'h2400), 32'h150,
              mkE(32'h150, 5'd1, 5'd9, 5'd9, 15'h2400, 0, 0, 1, 0, 0, 4'h2, 2'b00, 0), w);
        check("arst_run_wait", w, 32'd0);

        for (int k = 0; k < 20 && expQ.size() != 0; k++) @(posedge clk);
        #1;
        check("scoreboard_drained", expQ.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
        $finish;
    end

endmodule
